// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Width of the memory latency down-counter; covers MEM_LAT-1 up to 6.
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Identifies which requester owns the transaction in flight.
  typedef logic owner_t;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-way round-robin picker: chooses a winner among two request lines.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
//
// Ports:
//   req_i     request lines, bit n = requester n
//   rr_ptr_i  requester favoured when both request
//   valid_o   at least one request present
//   winner_o  selected requester (meaningful only when valid_o)
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     rr_ptr_i,
  output logic       valid_o,
  output owner_t     winner_o
);

  always_comb begin
    valid_o  = |req_i;
    // A lone requester always wins; the pointer only breaks ties.
    winner_o = (req_i == 2'b11) ? rr_ptr_i : req_i[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data-memory/IO bus between the core LSU (port 0)
// and the debug/boot loader (port 1) with round-robin arbitration.
// Latency: grant 1 cycle after request sampled, response MEM_LAT+1 cycles
// after grant; one transaction in flight, MEM_LAT+3 cycles per transaction.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mN_req_i/we/addr/wdata/be    requester N command, held until mN_gnt_o
//   mN_gnt_o                     one-cycle grant pulse
//   mN_rvalid_o, mN_rdata_o      one-cycle response pulse, sticky read data
//   mem_*                        single-port memory/IO bus
//   busy_o                       a transaction is in flight
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [3:0]        m0_be_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [3:0]        m1_be_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_lat
    $error("dmem_arbiter: MEM_LAT must be in 1..7");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  owner_t            rr_q, rr_d;
  owner_t            own_q, own_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q;

  logic              pick_vld;
  owner_t            pick_win;

  arb_rr2 u_rr2 (
    .req_i    ({m1_req_i, m0_req_i}),
    .rr_ptr_i (rr_q),
    .valid_o  (pick_vld),
    .winner_o (pick_win)
  );

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here become visible in the cycle after the edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    own_d       = own_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          // Capture the winner's command; the requester may drop or
          // change its fields from here on without affecting this access.
          own_d       = pick_win;
          mem_we_d    = pick_win ? m1_we_i    : m0_we_i;
          mem_addr_d  = pick_win ? m1_addr_i  : m0_addr_i;
          mem_wdata_d = pick_win ? m1_wdata_i : m0_wdata_i;
          mem_be_d    = pick_win ? m1_be_i    : m0_be_i;
          mem_en_d    = 1'b1;
          gnt_d       = {pick_win, ~pick_win};
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rr_d    = ~own_q;
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Last WAIT edge: memory data is valid now.
          rvalid_d = {own_q, ~own_q};
          if (!mem_we_q) begin
            if (own_q) rdata1_d = mem_rdata_i;
            else       rdata0_d = mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      own_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      // Registered copy of (state != IDLE) aligned with the state register.
      busy_q      <= (state_d != IDLE);
    end
  end

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: two instances (MEM_LAT=1 and 3),
// directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-schedule model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [3:0]  be    [2][2];
  logic        gnt   [2][2];
  logic        rv    [2][2];
  logic [31:0] rdata [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .m0_req_i    (req[g][0]),
      .m0_we_i     (we[g][0]),
      .m0_addr_i   (addr[g][0]),
      .m0_wdata_i  (wdata[g][0]),
      .m0_be_i     (be[g][0]),
      .m0_gnt_o    (gnt[g][0]),
      .m0_rvalid_o (rv[g][0]),
      .m0_rdata_o  (rdata[g][0]),
      .m1_req_i    (req[g][1]),
      .m1_we_i     (we[g][1]),
      .m1_addr_i   (addr[g][1]),
      .m1_wdata_i  (wdata[g][1]),
      .m1_be_i     (be[g][1]),
      .m1_gnt_o    (gnt[g][1]),
      .m1_rvalid_o (rv[g][1]),
      .m1_rdata_o  (rdata[g][1]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_be_o    (mem_be[g]),
      .mem_rdata_i (mem_rdata[g]),
      .busy_o      (busy[g])
    );
  end

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  int vecs = 0;
  int errs = 0;
  bit chk_on  = 1'b0;
  bit rand_on = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph = -1 when idle, otherwise cycles since the grant became visible:
  // 0 = grant/strobe cycle, 1..L = memory wait, L+1 = response cycle.
  int          ph     [2] = '{-1, -1};
  bit          own_m  [2];
  bit          rr_m   [2];
  bit          c_we   [2];
  logic [31:0] c_addr [2];
  logic [31:0] c_wdata[2];
  logic [3:0]  c_be   [2];
  logic [31:0] e_rd   [2][2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int w;
      if (rst[i]) begin
        ph[i] = -1; rr_m[i] = 1'b0; own_m[i] = 1'b0;
        c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0; c_be[i] = '0;
        e_rd[i][0] = '0; e_rd[i][1] = '0;
      end else if (ph[i] < 0) begin
        if (req[i][0] || req[i][1]) begin
          if (req[i][0] && req[i][1]) w = int'(rr_m[i]);
          else                        w = req[i][1] ? 1 : 0;
          own_m[i]   = w[0];
          rr_m[i]    = !w[0];
          c_we[i]    = we[i][w];
          c_addr[i]  = addr[i][w];
          c_wdata[i] = wdata[i][w];
          c_be[i]    = be[i][w];
          ph[i]      = 0;
        end
      end else if (ph[i] == lat(i) + 1) begin
        ph[i] = -1;
      end else begin
        ph[i]++;
        if (ph[i] == lat(i) + 1 && !c_we[i]) e_rd[i][own_m[i]] = mem_rdata[i];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d busy", i), busy[i], ph[i] >= 0);
        chk($sformatf("u%0d mem_en", i), mem_en[i], ph[i] == 0);
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("u%0d m%0d_gnt", i, p), gnt[i][p],
              ph[i] == 0 && int'(own_m[i]) == p);
          chk($sformatf("u%0d m%0d_rvalid", i, p), rv[i][p],
              ph[i] == lat(i) + 1 && int'(own_m[i]) == p);
          chk($sformatf("u%0d m%0d_rdata", i, p), rdata[i][p], e_rd[i][p]);
        end
        if (ph[i] >= 0) begin
          chk($sformatf("u%0d mem_we", i), mem_we[i], c_we[i]);
          chk($sformatf("u%0d mem_addr", i), mem_addr[i], c_addr[i]);
          chk($sformatf("u%0d mem_wdata", i), mem_wdata[i], c_wdata[i]);
          chk($sformatf("u%0d mem_be", i), mem_be[i], c_be[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic setreq(int i, int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; be[i][p] = b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random requesters: hold requests until granted, sometimes re-request
  // straight after a grant, occasionally drop a pending request.
  always @(negedge clk) begin
    if (rand_on) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]       = ($urandom_range(199) == 0);
        mem_rdata[i] = $urandom;
        for (int p = 0; p < 2; p++) begin
          if (ph[i] == 0 && int'(own_m[i]) == p) begin
            if ($urandom_range(1) == 0) req[i][p] = 1'b0;
            else setreq(i, p, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
          end else if (req[i][p]) begin
            if ($urandom_range(15) == 0) req[i][p] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            setreq(i, p, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; mem_rdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0; be[i][p] = '0;
      end
    end
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset then idle: everything quiet for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        chk("idle busy", busy[i], 0);
        chk("idle mem_en", mem_en[i], 0);
        chk("idle mem_addr", mem_addr[i], 0);
        chk("idle gnt", {gnt[i][1], gnt[i][0]}, 0);
        chk("idle rvalid", {rv[i][1], rv[i][0]}, 0);
        chk("idle rdata0", rdata[i][0], 0);
      end
    end

    // Single read on the MEM_LAT=1 instance.
    mem_rdata[0] = 32'hDEADBEEF;
    setreq(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
    step();
    chk("rd gnt0", gnt[0][0], 1);
    chk("rd mem_en", mem_en[0], 1);
    chk("rd mem_addr", mem_addr[0], 32'h100);
    chk("rd gnt1", gnt[0][1], 0);
    req[0][0] = 1'b0;
    step();
    chk("rd wait en", mem_en[0], 0);
    chk("rd wait rvalid", rv[0][0], 0);
    step();
    chk("rd rvalid0", rv[0][0], 1);
    chk("rd rdata0", rdata[0][0], 32'hDEADBEEF);
    chk("rd rvalid1", rv[0][1], 0);
    chk("rd rdata1", rdata[0][1], 0);
    step();
    chk("rd done busy", busy[0], 0);

    // Contention after reset: grants alternate every 4 cycles.
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rst clears rdata0", rdata[0][0], 0);
    setreq(0, 0, 1'b0, 32'h200, 32'h0, 4'h3);
    setreq(0, 1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'hC);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("cont gnt0 k%0d", k), gnt[0][0], (k == 1 || k == 9));
      chk($sformatf("cont gnt1 k%0d", k), gnt[0][1], (k == 5));
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    repeat (5) step();

    // Write ack on the MEM_LAT=3 instance; captured fields survive input churn.
    mem_rdata[1] = 32'hBAD0BAD0;
    setreq(1, 1, 1'b1, 32'h7000, 32'h12345678, 4'hF);
    step();
    chk("wr gnt1", gnt[1][1], 1);
    chk("wr mem_en", mem_en[1], 1);
    chk("wr mem_we", mem_we[1], 1);
    chk("wr mem_addr", mem_addr[1], 32'h7000);
    chk("wr mem_wdata", mem_wdata[1], 32'h12345678);
    chk("wr mem_be", mem_be[1], 4'hF);
    setreq(1, 1, 1'b0, 32'hFFFF, 32'h0, 4'h0);
    req[1][1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("wr wait en", mem_en[1], 0);
      chk("wr wait rvalid", rv[1][1], 0);
      chk("wr wait addr", mem_addr[1], 32'h7000);
      chk("wr wait wdata", mem_wdata[1], 32'h12345678);
    end
    step();
    chk("wr rvalid1", rv[1][1], 1);
    chk("wr rdata1 kept", rdata[1][1], 0);
    step();

    // Reset during WAIT of an m0 read: abandoned, no response ever.
    setreq(0, 0, 1'b0, 32'h400, 32'h0, 4'hF);
    step();
    req[0][0] = 1'b0;
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rstmid busy", busy[0], 0);
    chk("rstmid mem_en", mem_en[0], 0);
    chk("rstmid rvalid0", rv[0][0], 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rstmid no rvalid", rv[0][0], 0);
      chk("rstmid no gnt", gnt[0][0], 0);
    end
    setreq(0, 0, 1'b0, 32'h404, 32'h0, 4'hF);
    setreq(0, 1, 1'b0, 32'h408, 32'h0, 4'hF);
    step();
    chk("rstmid rr0 gnt0", gnt[0][0], 1);
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    repeat (4) step();
    setreq(0, 1, 1'b0, 32'h40C, 32'h0, 4'h1);
    step();
    chk("m1 only gnt1", gnt[0][1], 1);
    req[0][1] = 1'b0;
    repeat (4) step();

    // m1 raises req during m0's grant cycle: served at the next IDLE.
    setreq(0, 0, 1'b0, 32'h500, 32'h0, 4'hF);
    step();
    chk("busyreq gnt0", gnt[0][0], 1);
    req[0][0] = 1'b0;
    setreq(0, 1, 1'b1, 32'h504, 32'h77, 4'h2);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("busyreq early gnt1 k%0d", k), gnt[0][1], 0);
    end
    step();
    chk("busyreq gnt1", gnt[0][1], 1);
    req[0][1] = 1'b0;
    repeat (4) step();

    // Randomized traffic on both instances.
    rand_on = 1'b1;
    repeat (4000) @(negedge clk);
    rand_on = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port data-memory/IO bus between two requesters.
  - Port 0: core LSU.
  - Port 1: debug/boot loader that preloads data memory and pokes IO registers.
- Round-robin arbitration, a registered request/grant/response handshake, and a fixed-latency memory access sequence, one transaction in flight at a time.
- Sits between the core's load/store path and the memory/IO block.

Parameters:
- ADDR_W, 32, address width of requesters and memory bus
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the memory-enable edge to valid mem_rdata_i; legal range 1..7, other values fail an elaboration assertion

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- m0_req_i  in  1  port 0 request; held with its fields until m0_gnt_o
- m0_we_i  in  1  port 0 write (1) / read (0)
- m0_addr_i  in  ADDR_W  port 0 byte address
- m0_wdata_i  in  DATA_W  port 0 store data
- m0_be_i  in  4  port 0 byte enables
- m0_gnt_o  out  1  port 0 grant pulse
- m0_rvalid_o  out  1  port 0 response pulse (read data or write ack)
- m0_rdata_o  out  DATA_W  port 0 read data
- m1_* : same eight signals for port 1
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  4  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - All outputs 0, including both rdata_o.
  - State IDLE, lat counter 0, rr_ptr 0 (port 0 has priority).
- All outputs are registered.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples both req at edge T.
  - If either is high, picks the winner, captures its we/addr/wdata/be and owner id, then moves to ISSUE.
  - Winner selection: if both request, winner = rr_ptr; if one requests, that one wins.
- ISSUE (cycle T+1):
  - mem_en_o=1 and the mem_* fields are driven from the capture.
  - gnt_o=1 for the owner only.
  - rr_ptr is set to the non-owner.
  - lat counter loaded with MEM_LAT-1; next state WAIT.
- WAIT:
  - mem_en_o=0; mem_addr/we/wdata/be hold their values.
  - Decrements the counter each cycle. Occupies MEM_LAT cycles (T+2..T+1+MEM_LAT), then moves to RESP.
  - mem_rdata_i is sampled into the owner's rdata register at the last WAIT edge.
- RESP (cycle T+2+MEM_LAT):
  - Owner rvalid_o=1.
  - Reads: owner rdata_o holds the sampled data.
  - Writes: rdata_o is unchanged; rvalid acts as the ack.
  - Next state IDLE.
- Rules:
  - The non-owner rdata_o never changes.
  - rdata_o holds its value until that port's next read response.
- Throughput: one transaction per MEM_LAT+3 cycles. With MEM_LAT=1, back-to-back transactions are granted 4 cycles apart.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.
- Boundary conditions:
  - Req dropped between sample and grant: the transaction still completes from the captured fields.
  - Req held high after gnt: treated as a new request at the next IDLE.
  - Requests arriving while busy: not sampled; the requester keeps req high until its gnt.
  - rst_i in any state: returns to IDLE next cycle. In-flight access is abandoned, with no gnt or rvalid emitted afterwards and mem_en_o=0.
- Width rules:
  - Addresses pass through unmodified; no alignment checks.
  - be is passed as given; writes with be=0 still complete and ack.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum arb_state_e (IDLE, ISSUE, WAIT, RESP);
  - typedef owner_t (1-bit);
  - localparam LAT_W = 3.
- One natural sub-module, arb_rr2: a 2-way round-robin picker.
  - Inputs: req[1:0], rr_ptr. Outputs: valid, winner.
  - Purely combinational, reused by future IO arbiters.
- The FSM and capture registers live in dmem_arbiter.

Test Plan:
- Reset then idle: assert rst_i 2 cycles, no reqs -> all outputs 0, busy_o=0 for 10 cycles.
- Single read: m0 read addr 0x100 at T, memory returns 0xDEADBEEF, MEM_LAT=1 ->
  - mem_en_o and m0_gnt_o at T+1 with mem_addr_o=0x100;
  - m0_rvalid_o at T+3 with m0_rdata_o=0xDEADBEEF;
  - m1 outputs stay 0.
- Contention: both req at T after reset ->
  - m0 granted at T+1, m1 granted at T+5;
  - then with both held, m0 at T+9 (alternation).
- Write ack: m1 write addr 0x7000, wdata 0x12345678, be 0xF, MEM_LAT=3 ->
  - mem_we_o=1 with those fields at T+1, fields stable through WAIT;
  - m1_rvalid_o at T+5;
  - m1_rdata_o unchanged.
- Reset mid-operation: rst_i asserted during WAIT of an m0 read -> next cycle IDLE, no m0_rvalid_o ever, rr_ptr=0. Then an m1-only req is granted normally.
- Request while busy: m1 raises req during m0's ISSUE -> m1 granted at the ISSUE that follows m0's RESP, with no gnt before that.
